// File: rtl/adc_spi_pkg.sv
// adc_spi_pkg: shared state encoding and default frame geometry for the ADC SPI receiver
package adc_spi_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;
    localparam int DEF_WORD_BITS = 16;
    localparam int DEF_CHANNELS  = 5;
endpackage

// File: rtl/adc_spi_rx_sync_edge.sv
// sync_edge: multi-flop synchroniser with rise/fall detection on the synchronised level
// ports: clk, reset_n (sync, active-low), d (async input), q (synchronised level), rise/fall (one-cycle pulses)
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] sync;
    logic prev;
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= STAGES'({sync, d});
            prev <= sync[STAGES-1];
        end
    end
    assign q    = sync[STAGES-1];
    assign rise = q & ~prev;
    assign fall = ~q & prev;
endmodule

// File: rtl/adc_spi_rx.sv
// adc_spi_rx: receives CS-framed MSB-first multi-channel ADC words and publishes validated frames
// ports: i_Clock (system clock), reset_n (sync, active-low), i_ADC_Clock/i_ADC_Data/i_ADC_CS (async serial bus),
//        o_Data (last good frame, channel 0 in the low word), o_Valid / o_Frame_Error (one-cycle pulses),
//        o_Error_Count (saturating rejected-frame count)
module adc_spi_rx import adc_spi_pkg::*; #(
    parameter int WORD_BITS   = DEF_WORD_BITS,
    parameter int CHANNELS    = DEF_CHANNELS,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          i_Clock,
    input  logic                          reset_n,
    input  logic                          i_ADC_Clock,
    input  logic                          i_ADC_Data,
    input  logic                          i_ADC_CS,
    output logic [CHANNELS*WORD_BITS-1:0] o_Data,
    output logic                          o_Valid,
    output logic                          o_Frame_Error,
    output logic [7:0]                    o_Error_Count
);
    localparam int BW = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
    localparam int WW = $clog2(CHANNELS + 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(WORD_BITS - 1);
    localparam logic [WW-1:0] WORD_FULL = WW'(CHANNELS);

    logic sck_q, sck_rise, sck_fall;
    logic d_q, d_rise, d_fall;
    logic cs_q, cs_rise, cs_fall;
    logic unused_edges;

    sync_edge #(.STAGES(SYNC_STAGES)) u_sck (.clk(i_Clock), .reset_n(reset_n), .d(i_ADC_Clock), .q(sck_q), .rise(sck_rise), .fall(sck_fall));
    sync_edge #(.STAGES(SYNC_STAGES)) u_dat (.clk(i_Clock), .reset_n(reset_n), .d(i_ADC_Data),  .q(d_q),   .rise(d_rise),   .fall(d_fall));
    sync_edge #(.STAGES(SYNC_STAGES)) u_cs  (.clk(i_Clock), .reset_n(reset_n), .d(i_ADC_CS),    .q(cs_q),  .rise(cs_rise),  .fall(cs_fall));

    assign unused_edges = ^{sck_q, sck_fall, d_rise, d_fall};

    state_t                        state;
    logic [BW-1:0]                 bit_cnt;
    logic [WW-1:0]                 word_cnt;
    logic [WORD_BITS-1:0]          shift_word;
    logic [WORD_BITS-1:0]          next_word;
    logic [CHANNELS*WORD_BITS-1:0] staging;
    logic                          overrun;
    logic                          start_pend;

    assign next_word = {shift_word[WORD_BITS-2:0], d_q};

    always_ff @(posedge i_Clock) begin
        if (!reset_n) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            word_cnt      <= '0;
            shift_word    <= '0;
            staging       <= '0;
            overrun       <= 1'b0;
            start_pend    <= 1'b0;
            o_Data        <= '0;
            o_Valid       <= 1'b0;
            o_Frame_Error <= 1'b0;
            o_Error_Count <= '0;
        end else begin
            o_Valid       <= 1'b0;
            o_Frame_Error <= 1'b0;
            case (state)
                IDLE: begin
                    // start_pend carries a CS fall that arrived while CHECK was busy
                    if (cs_fall || start_pend) begin
                        state      <= SHIFT;
                        bit_cnt    <= '0;
                        word_cnt   <= '0;
                        overrun    <= 1'b0;
                        start_pend <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        state <= CHECK;
                    end else if (sck_rise && !cs_q) begin
                        // bits beyond a full frame are dropped but poison the frame
                        if (word_cnt == WORD_FULL) begin
                            overrun <= 1'b1;
                        end else begin
                            shift_word <= next_word;
                            if (bit_cnt == BIT_LAST) begin
                                staging[word_cnt*WORD_BITS +: WORD_BITS] <= next_word;
                                word_cnt <= word_cnt + 1'b1;
                                bit_cnt  <= '0;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                end
                CHECK: begin
                    state      <= IDLE;
                    start_pend <= cs_fall;
                    if (word_cnt == WORD_FULL && bit_cnt == '0 && !overrun) begin
                        o_Data  <= staging;
                        o_Valid <= 1'b1;
                    end else begin
                        o_Frame_Error <= 1'b1;
                        if (o_Error_Count != 8'hFF)
                            o_Error_Count <= o_Error_Count + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adc_spi_rx.sv
// tb_adc_spi_rx: directed scoreboard bench for adc_spi_rx (default geometry plus a 12x8 instance for saturation)
`timescale 1ns/1ps
module tb_adc_spi_rx;
    localparam int WB = 16, CH = 5, FW = WB * CH;
    localparam int W2 = 12, C2 = 8;
    localparam int HALF = 375;
    localparam int LAT_BUDGET = 6;

    logic i_Clock = 1'b0, reset_n = 1'b0;
    logic i_ADC_Clock = 1'b1, i_ADC_Data = 1'b0, i_ADC_CS = 1'b1;
    logic [FW-1:0] o_Data;
    logic o_Valid, o_Frame_Error;
    logic [7:0] o_Error_Count;
    logic [W2*C2-1:0] o_Data2;
    logic o_Valid2, o_Frame_Error2;
    logic [7:0] o_Error_Count2;

    always #10.417 i_Clock = ~i_Clock;

    adc_spi_rx dut (
        .i_Clock(i_Clock), .reset_n(reset_n), .i_ADC_Clock(i_ADC_Clock), .i_ADC_Data(i_ADC_Data), .i_ADC_CS(i_ADC_CS),
        .o_Data(o_Data), .o_Valid(o_Valid), .o_Frame_Error(o_Frame_Error), .o_Error_Count(o_Error_Count)
    );

    adc_spi_rx #(.WORD_BITS(W2), .CHANNELS(C2)) dut2 (
        .i_Clock(i_Clock), .reset_n(reset_n), .i_ADC_Clock(i_ADC_Clock), .i_ADC_Data(i_ADC_Data), .i_ADC_CS(i_ADC_CS),
        .o_Data(o_Data2), .o_Valid(o_Valid2), .o_Frame_Error(o_Frame_Error2), .o_Error_Count(o_Error_Count2)
    );

    typedef struct { bit v; logic [FW-1:0] d; } ev_t;
    ev_t sb[$];
    ev_t mon_e;
    int total = 0, bad = 0;

    localparam logic [FW-1:0] F1 = {16'h007B, 16'h0067, 16'h01FA, 16'h0000, 16'h0000};
    localparam logic [FW-1:0] F2 = {16'h1234, 16'hABCD, 16'h0F0F, 16'hFFFF, 16'h8001};
    localparam logic [FW-1:0] FA = {16'hA5A5, 16'h5A5A, 16'h0001, 16'h8000, 16'h7FFE};
    localparam logic [FW-1:0] FB = {16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D, 16'h1357};
    localparam logic [FW-1:0] FC = {16'h0102, 16'h0304, 16'h0506, 16'h0708, 16'h090A};

    // serial order is channel 0 first; o_Data holds channel 0 in the low word
    function automatic logic [FW-1:0] packed_of(input logic [FW-1:0] s);
        logic [FW-1:0] r;
        for (int i = 0; i < CH; i++) r[i*WB +: WB] = s[(CH-1-i)*WB +: WB];
        return r;
    endfunction

    function automatic ev_t ev(input bit v, input logic [FW-1:0] s);
        ev_t e;
        e.v = v;
        e.d = v ? packed_of(s) : '0;
        return e;
    endfunction

    task automatic send_bits(input logic [95:0] vec, input int n);
        for (int i = 0; i < n; i++) begin
            i_ADC_Clock = 1'b0;
            i_ADC_Data  = vec[n-1-i];
            #(HALF);
            i_ADC_Clock = 1'b1;
            #(HALF);
        end
    endtask

    task automatic frame(input logic [95:0] vec, input int n);
        i_ADC_CS = 1'b0;
        #(HALF);
        send_bits(vec, n);
        #(HALF);
        i_ADC_CS = 1'b1;
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < LAT_BUDGET && sb.size() > 0; k++) @(posedge i_Clock);
        @(negedge i_Clock);
        total++;
        assert (sb.size() == 0) else begin
            bad++;
            $error("FAIL %s: pending events=%0d required=0", tag, sb.size());
        end
    endtask

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    always @(negedge i_Clock) begin
        if (o_Valid || o_Frame_Error) begin
            total++;
            assert (!(o_Valid && o_Frame_Error)) else begin
                bad++;
                $error("FAIL both_pulses: valid=%0b err=%0b expected one", o_Valid, o_Frame_Error);
            end
            total++;
            assert (sb.size() != 0) else begin
                bad++;
                $error("FAIL unexpected_event: valid=%0b err=%0b expected none", o_Valid, o_Frame_Error);
            end
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                total++;
                assert (o_Valid === mon_e.v) else begin
                    bad++;
                    $error("FAIL event_kind: valid=%0b expected valid=%0b", o_Valid, mon_e.v);
                end
                if (mon_e.v) begin
                    total++;
                    assert (o_Data === mon_e.d) else begin
                        bad++;
                        $error("FAIL frame_data: observed=%0h expected=%0h", o_Data, mon_e.d);
                    end
                end
            end
        end
    end

    initial begin
        repeat (5) @(negedge i_Clock);
        chk("rst_data", o_Data, 0);
        chk("rst_valid", o_Valid, 0);
        chk("rst_ferr", o_Frame_Error, 0);
        chk("rst_cnt", o_Error_Count, 0);
        reset_n = 1'b1;
        repeat (5) @(negedge i_Clock);

        // SCK activity with CS high must not produce anything
        i_ADC_Data = 1'b1;
        for (int i = 0; i < 8; i++) begin
            i_ADC_Clock = ~i_ADC_Clock;
            #(HALF);
        end
        i_ADC_Clock = 1'b1;
        chk("cs_high_sck", o_Data, 0);

        sb.push_back(ev(1, F1));
        frame(F1, 80);
        drain("good_latency");
        chk("good_data", o_Data, packed_of(F1));
        chk("good_cnt", o_Error_Count, 0);
        #1000;

        sb.push_back(ev(0, '0));
        frame(F1 >> 32, 48);
        drain("short_latency");
        chk("short_hold", o_Data, packed_of(F1));
        chk("short_cnt", o_Error_Count, 1);
        #1000;

        sb.push_back(ev(0, '0));
        frame({F2, 1'b1}, 81);
        drain("extra_latency");
        chk("extra_hold", o_Data, packed_of(F1));
        chk("extra_cnt", o_Error_Count, 2);
        #1000;

        sb.push_back(ev(1, F2));
        frame(F2, 80);
        drain("after_extra_latency");
        chk("after_extra_data", o_Data, packed_of(F2));
        chk("after_extra_cnt", o_Error_Count, 2);
        #1000;

        sb.push_back(ev(0, '0));
        frame(F2 >> 8, 72);
        drain("partial_latency");
        chk("partial_hold", o_Data, packed_of(F2));
        chk("partial_cnt", o_Error_Count, 3);
        #1000;

        sb.push_back(ev(1, FA));
        sb.push_back(ev(1, FB));
        frame(FA, 80);
        #200;
        frame(FB, 80);
        drain("b2b_latency");
        chk("b2b_data", o_Data, packed_of(FB));
        #1000;

        i_ADC_CS = 1'b0;
        #(HALF);
        send_bits(FA >> 56, 24);
        @(negedge i_Clock);
        reset_n = 1'b0;
        repeat (4) @(negedge i_Clock);
        chk("midrst_data", o_Data, 0);
        chk("midrst_cnt", o_Error_Count, 0);
        reset_n = 1'b1;
        send_bits(FA, 56);
        #(HALF);
        i_ADC_CS = 1'b1;
        repeat (30) @(negedge i_Clock);
        chk("discarded_data", o_Data, 0);
        chk("discarded_cnt", o_Error_Count, 0);
        #1000;
        sb.push_back(ev(1, FC));
        frame(FC, 80);
        drain("post_rst_latency");
        chk("post_rst_data", o_Data, packed_of(FC));
        chk("dut2_geom_reject", o_Error_Count2, 1);

        for (int n = 1; n <= 256; n++) begin
            sb.push_back(ev(0, '0));
            i_ADC_CS = 1'b0;
            repeat (6) @(negedge i_Clock);
            i_ADC_CS = 1'b1;
            repeat (10) @(negedge i_Clock);
            if (n == 253) chk("dut2_cnt_254", o_Error_Count2, 254);
            if (n == 254) chk("cnt_254", o_Error_Count, 254);
            if (n == 255) chk("cnt_255", o_Error_Count, 255);
        end
        drain("sat_events");
        chk("cnt_sat", o_Error_Count, 255);
        chk("dut2_cnt_sat", o_Error_Count2, 255);
        chk("sat_hold", o_Data, packed_of(FC));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
